// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-scheduling / keystream blocks that sit
// around the single-port 256x8 S-memory.
//   MEM_DEPTH      : number of S-memory entries (one per byte value)
//   DEF_KEY_BYTES  : default secret key length in bytes
//   ksa_state_t    : state encoding of the KSA swap loop, also used by the
//                    PRGA loop and by the top-level memory mux to decide
//                    which block owns the memory port
// ---------------------------------------------------------------------------
package rc4_pkg;

  localparam int MEM_DEPTH     = 256;
  localparam int DEF_KEY_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_I   = 3'd1,
    WAIT_I = 3'd2,
    RD_J   = 3'd3,
    WAIT_J = 3'd4,
    WR_I   = 3'd5,
    WR_J   = 3'd6,
    DONE   = 3'd7
  } ksa_state_t;

endpackage

// File: rtl/ksa_swap_loop.sv
// ---------------------------------------------------------------------------
// ksa_swap_loop
// Second phase of RC4 key scheduling. Starting from S[i]=i, walks i=0..255:
// reads S[i], forms j = j + S[i] + key[i mod KEY_BYTES], reads S[j], then
// writes S[i]=S[j] and S[j]=S[i]. Each iteration takes 4+2*READ_LATENCY
// cycles. All outputs are registered.
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   start_flag  : level, sampled only in IDLE (tie to init loop done_flag)
//   start_over  : level, sampled only in DONE, returns the block to IDLE
//   secret_key  : key, byte 0 in the most significant byte; latched on start
//   q           : S-memory read data, valid READ_LATENCY cycles after address
//   address     : S-memory address
//   data        : S-memory write data
//   wren        : S-memory write enable (only in WR_I / WR_J)
//   done_flag   : high while in DONE
//   state_dbg   : current FSM state, for observation only
//
// Parameters
//   KEY_BYTES    : secret key length in bytes
//   READ_LATENCY : memory read latency in cycles, 1 or 2
// ---------------------------------------------------------------------------
module ksa_swap_loop
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES    = DEF_KEY_BYTES,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_flag,
  input  logic                   start_over,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic                   done_flag,
  output ksa_state_t             state_dbg
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  // Wait counter counts 0..READ_LATENCY-1; data is sampled on the last count.
  localparam logic [1:0]        WAIT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [7:0]        I_LAST    = 8'(MEM_DEPTH - 1);

  ksa_state_t             state_q;
  logic [7:0]             i_q;
  logic [7:0]             j_q;
  logic [7:0]             si_q;
  logic [KIDX_W-1:0]      k_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [1:0]             wait_q;
  logic [7:0]             address_q;
  logic [7:0]             data_q;
  logic                   wren_q;
  logic                   done_q;

  logic [7:0]             key_byte;
  logic [7:0]             j_d;

  // Key byte select: index 0 is the most significant byte of the key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KIDX_W'(b)) begin
        key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  // New j formed from the S[i] value currently on q (mod 256).
  assign j_d = j_q + q + key_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      k_q       <= '0;
      key_q     <= '0;
      wait_q    <= '0;
      address_q <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wren_q <= 1'b0;
          if (start_flag) begin
            key_q     <= secret_key;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            address_q <= '0;
            state_q   <= RD_I;
          end
        end

        RD_I: begin
          wait_q  <= '0;
          state_q <= WAIT_I;
        end

        WAIT_I: begin
          if (wait_q == WAIT_LAST) begin
            si_q      <= q;
            j_q       <= j_d;
            address_q <= j_d;
            state_q   <= RD_J;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end

        RD_J: begin
          wait_q  <= '0;
          state_q <= WAIT_J;
        end

        WAIT_J: begin
          if (wait_q == WAIT_LAST) begin
            // S[j] goes straight into the write-data register for WR_I.
            data_q    <= q;
            address_q <= i_q;
            wren_q    <= 1'b1;
            state_q   <= WR_I;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end

        WR_I: begin
          address_q <= j_q;
          data_q    <= si_q;
          wren_q    <= 1'b1;
          state_q   <= WR_J;
        end

        WR_J: begin
          wren_q <= 1'b0;
          if (i_q == I_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            // The write to S[j] completes at this edge, so reading S[i+1]
            // next cycle is safe even when i+1 == j.
            i_q       <= i_q + 8'd1;
            address_q <= i_q + 8'd1;
            k_q       <= (k_q == KIDX_LAST) ? '0 : k_q + 1'b1;
            state_q   <= RD_I;
          end
        end

        DONE: begin
          wren_q <= 1'b0;
          if (start_over) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          wren_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign address   = address_q;
  assign data      = data_q;
  assign wren      = wren_q;
  assign done_flag = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ksa_swap_loop.sv
// ---------------------------------------------------------------------------
// tb_ksa_swap_loop
// Drives two instances (READ_LATENCY 1 and 2) from shared stimulus, each
// backed by its own behavioural single-port RAM. A software KSA model
// produces the expected write sequence and final S contents.
// ---------------------------------------------------------------------------
module tb_ksa_swap_loop;
  import rc4_pkg::*;

  localparam int KB = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_flag;
  logic        start_over;
  logic [23:0] secret_key;
  logic        ram_load;

  logic [7:0]  q1, q2, q2_p;
  logic [7:0]  addr1, addr2, data1, data2;
  logic        wren1, wren2, done1, done2;
  ksa_state_t  st1, st2;

  logic [7:0]  ram1 [256];
  logic [7:0]  ram2 [256];

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q1 [$];
  logic [15:0] exp_q2 [$];
  logic [7:0]  exp_s  [256];

  ksa_swap_loop #(.KEY_BYTES(KB), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start_flag(start_flag), .start_over(start_over),
    .secret_key(secret_key), .q(q1), .address(addr1), .data(data1),
    .wren(wren1), .done_flag(done1), .state_dbg(st1)
  );

  ksa_swap_loop #(.KEY_BYTES(KB), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start_flag(start_flag), .start_over(start_over),
    .secret_key(secret_key), .q(q2), .address(addr2), .data(data2),
    .wren(wren2), .done_flag(done2), .state_dbg(st2)
  );

  // ---------------- behavioural RAMs ----------------
  always @(posedge clk) begin
    if (ram_load) for (int k = 0; k < 256; k++) ram1[k] <= 8'(k);
    else if (wren1) ram1[addr1] <= data1;
    q1 <= ram1[addr1];
  end

  always @(posedge clk) begin
    if (ram_load) for (int k = 0; k < 256; k++) ram2[k] <= 8'(k);
    else if (wren2) ram2[addr2] <= data2;
    q2_p <= ram2[addr2];
    q2   <= q2_p;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Software KSA: expected write stream {addr,data} and final S.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    exp_q1.delete();
    exp_q2.delete();
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'((key >> (8 * (KB - 1 - (i % KB)))) & 24'hFF);
      j  = j + s[i] + kb;
      exp_q1.push_back({8'(i), s[j]});
      exp_q1.push_back({j, s[i]});
      exp_q2.push_back({8'(i), s[j]});
      exp_q2.push_back({j, s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) exp_s[k] = s[k];
  endtask

  // ---------------- write-stream compare processes ----------------
  always @(negedge clk) begin
    if (!reset && wren1) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_rl1_extra: got write %0h=%0h want no write", addr1, data1);
      end else begin
        check("wr_rl1", {16'd0, addr1, data1}, {16'd0, exp_q1.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && wren2) begin
      if (exp_q2.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_rl2_extra: got write %0h=%0h want no write", addr2, data2);
      end else begin
        check("wr_rl2", {16'd0, addr2, data2}, {16'd0, exp_q2.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_ram();
    @(negedge clk); ram_load = 1'b1;
    @(negedge clk); ram_load = 1'b0;
  endtask

  // Returns 1 ns after the acceptance edge; key is then disturbed.
  task automatic start_run(input logic [23:0] key);
    build_model(key);
    @(negedge clk); secret_key = key; start_flag = 1'b1;
    @(posedge clk); #1;
    start_flag = 1'b0;
    secret_key = ~key;
  endtask

  // pin: 1 = key 010203 literals, 2 = key 000000 literals, 0 = none
  task automatic wait_done(input int pin);
    int n, n1, n2;
    n = 0; n1 = 0; n2 = 0;
    while ((n1 == 0 || n2 == 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (done1 && n1 == 0) n1 = n;
      if (done2 && n2 == 0) n2 = n;
      if (n == 100) start_flag = 1'b1;
      if (n == 101) start_flag = 1'b0;
      if (n == 200) start_over = 1'b1;
      if (n == 201) start_over = 1'b0;
      if (pin == 1 && n == 6) begin
        check("it0_s0", 32'(ram1[0]), 32'h01);
        check("it0_s1", 32'(ram1[1]), 32'h00);
      end
      if (pin == 1 && n == 12) begin
        check("it1_s1", 32'(ram1[1]), 32'h03);
        check("it1_s3", 32'(ram1[3]), 32'h00);
      end
      if (pin == 2 && n == 6) begin
        check("k0_it0_s0", 32'(ram1[0]), 32'h00);
        check("k0_it0_s1", 32'(ram1[1]), 32'h01);
      end
    end
    check("done_cycles_rl1", 32'(n1), 32'd1536);
    check("done_cycles_rl2", 32'(n2), 32'd2048);
  endtask

  task automatic final_check();
    int m1, m2;
    m1 = 0; m2 = 0;
    for (int k = 0; k < 256; k++) begin
      if (ram1[k] !== exp_s[k]) m1++;
      if (ram2[k] !== exp_s[k]) m2++;
    end
    check("final_s_rl1_bad_bytes", 32'(m1), 32'd0);
    check("final_s_rl2_bad_bytes", 32'(m2), 32'd0);
    check("writes_left_rl1", 32'(exp_q1.size()), 32'd0);
    check("writes_left_rl2", 32'(exp_q2.size()), 32'd0);
  endtask

  task automatic leave_done();
    @(negedge clk); start_over = 1'b1;
    @(posedge clk); #1;
    start_over = 1'b0;
    check("leave_done1", {31'd0, done1}, 32'd0);
    check("leave_done2", {31'd0, done2}, 32'd0);
    check("leave_state1", 32'(st1), 32'(IDLE));
    check("leave_state2", 32'(st2), 32'(IDLE));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr1"}, 32'(addr1), 32'd0);
    check({tag, "_data1"}, 32'(data1), 32'd0);
    check({tag, "_wren1"}, {31'd0, wren1}, 32'd0);
    check({tag, "_done1"}, {31'd0, done1}, 32'd0);
    check({tag, "_state1"}, 32'(st1), 32'(IDLE));
    check({tag, "_wren2"}, {31'd0, wren2}, 32'd0);
    check({tag, "_done2"}, {31'd0, done2}, 32'd0);
    check({tag, "_state2"}, 32'(st2), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start_flag = 1'b0; start_over = 1'b0;
    secret_key = 24'd0; ram_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk); reset = 1'b0;

    // Run A: key 010203, literal pins on model and on memory contents.
    load_ram();
    start_run(24'h010203);
    check("model_w0", 32'(exp_q1[0]), 32'h0001);
    check("model_w1", 32'(exp_q1[1]), 32'h0100);
    check("model_w2", 32'(exp_q1[2]), 32'h0103);
    check("model_w3", 32'(exp_q1[3]), 32'h0300);
    wait_done(1);
    final_check();
    leave_done();

    // Run B: reset mid-run at cycle 700, then a clean run.
    load_ram();
    start_run(24'h010203);
    repeat (699) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midrst");
    @(negedge clk); reset = 1'b0;
    load_ram();
    start_run(24'h010203);
    wait_done(0);
    final_check();
    leave_done();

    // Run C: all-zero key, iteration 0 has i == j == 0.
    load_ram();
    start_run(24'h000000);
    check("k0_model_w0", 32'(exp_q1[0]), 32'h0000);
    check("k0_model_w1", 32'(exp_q1[1]), 32'h0000);
    check("k0_model_w2", 32'(exp_q1[2]), 32'h0101);
    wait_done(2);
    final_check();

    // DONE is sticky against start_flag activity.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); start_flag = ~start_flag;
      @(posedge clk); #1;
      check("done_hold1", {31'd0, done1}, 32'd1);
      check("done_hold2", {31'd0, done2}, 32'd1);
      check("done_state1", 32'(st1), 32'(DONE));
      check("done_wren1", {31'd0, wren1}, 32'd0);
    end
    @(negedge clk); start_flag = 1'b0;
    leave_done();

    // Run D: second full pass with a new key.
    load_ram();
    start_run(24'hFFFFFF);
    wait_done(0);
    final_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
